acc_window: RTL and testbench

ACC_WINDOW -- requirements
Module: acc_window

---
 rtl/acc_window_pkg.sv | 23 ++
 rtl/acc_window_win_counter.sv | 92 +++++++++
 rtl/acc_window.sv | 86 ++++++++
 tb/tb_acc_window.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_window_pkg.sv
// acc_window_pkg: types and helpers shared by the window accumulator.
//   win_state_t : window state (EMPTY = no sample held, ACCUM = partial window)
//   clog2()     : ceiling log2, used to size counter and sum widths
package acc_window_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } win_state_t;

    // Ceiling log2 for elaboration-time width computation; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/acc_window_win_counter.sv
// win_counter: sample counter and window-state FSM for acc_window.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage enable; 0 freezes the counter and state
//   accept     : a sample is taken this cycle
//   flush      : close the current partial window
//   state      : EMPTY / ACCUM
//   emit       : the window closes at the next edge
//   emit_cnt   : number of samples in the closing window (includes this cycle's sample)
module win_counter
    import acc_window_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = clog2(W),
    parameter int DW = clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          accept,
    input  logic          flush,
    output win_state_t    state,
    output logic          emit,
    output logic [DW-1:0] emit_cnt
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    win_state_t    state_next_s;
    logic          last_s;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            cnt_r <= {CW{1'b0}};
        end else begin
            state <= state_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    // Next-state, terminal-count and flush-qualify logic.
    always_comb begin
        state_next_s = state;
        cnt_next_s   = cnt_r;
        emit         = 1'b0;
        // The W-th sample arrives while CNT already holds W-1.
        last_s       = accept && (cnt_r == CW'(W - 1));
        emit_cnt     = DW'(cnt_r) + DW'(accept);
        if (en) begin
            case (state)
                ST_EMPTY: begin
                    // Flush with nothing held and nothing arriving emits nothing.
                    if (accept) begin
                        if (last_s || flush) begin
                            emit         = 1'b1;
                            cnt_next_s   = {CW{1'b0}};
                            state_next_s = ST_EMPTY;
                        end else begin
                            cnt_next_s   = CW'(1);
                            state_next_s = ST_ACCUM;
                        end
                    end else begin
                        cnt_next_s   = {CW{1'b0}};
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ACCUM: begin
                    if (last_s || flush) begin
                        emit         = 1'b1;
                        cnt_next_s   = {CW{1'b0}};
                        state_next_s = ST_EMPTY;
                    end else if (accept) begin
                        cnt_next_s   = cnt_r + CW'(1);
                        state_next_s = ST_ACCUM;
                    end else begin
                        cnt_next_s   = cnt_r;
                        state_next_s = ST_ACCUM;
                    end
                end
                default: begin
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = ST_EMPTY;
                end
            endcase
        end else begin
            state_next_s = state;
            cnt_next_s   = cnt_r;
        end
    end

endmodule

// File: rtl/acc_window.sv
// acc_window: sums W consecutive unsigned samples and emits the window sum.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   en         : stage enable; 0 freezes all state including outputs
//   r_in, d_in : sample valid / unsigned N-bit sample
//   flush      : close the current partial window early
//   r_out      : result valid (registered)
//   d_out      : AW-bit window sum (registered)
//   d_cnt      : number of samples summed into d_out (registered)
module acc_window
    import acc_window_pkg::*;
#(
    parameter int N  = 16,
    parameter int W  = 4,
    parameter int AW = N + clog2(W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    r_in,
    input  logic [N-1:0]            d_in,
    input  logic                    flush,
    output logic                    r_out,
    output logic [AW-1:0]           d_out,
    output logic [clog2(W+1)-1:0]   d_cnt
);

    localparam int DW = clog2(W + 1);

    logic          accept_s;
    logic          emit_s;
    logic [DW-1:0] emit_cnt_s;
    win_state_t    state_s;
    logic [AW-1:0] acc_r;
    logic [AW-1:0] sum_s;

    assign accept_s = en && r_in;

    win_counter #(
        .W (W)
    ) u_win_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .accept   (accept_s),
        .flush    (flush),
        .state    (state_s),
        .emit     (emit_s),
        .emit_cnt (emit_cnt_s)
    );

    // Running sum including this cycle's sample; EMPTY starts a fresh window.
    always_comb begin
        sum_s = {AW{1'b0}};
        if (state_s == ST_EMPTY) begin
            sum_s = {AW{1'b0}};
        end else begin
            sum_s = acc_r;
        end
        if (accept_s) begin
            sum_s = sum_s + AW'(d_in);
        end else begin
            sum_s = sum_s;
        end
    end

    // Accumulator and output registers; everything holds while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {AW{1'b0}};
            r_out <= 1'b0;
            d_out <= {AW{1'b0}};
            d_cnt <= {DW{1'b0}};
        end else if (en) begin
            if (emit_s) begin
                acc_r <= {AW{1'b0}};
                r_out <= 1'b1;
                d_out <= sum_s;
                d_cnt <= emit_cnt_s;
            end else begin
                acc_r <= accept_s ? sum_s : acc_r;
                r_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_window.sv
// tb_acc_window: directed self-checking bench for acc_window (N=16, W=4).
module tb_acc_window;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        r_in;
    logic [15:0] d_in;
    logic        flush;
    logic        r_out;
    logic [17:0] d_out;
    logic [2:0]  d_cnt;

    int checks;
    int errors;

    acc_window #(.N(16), .W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .r_in  (r_in),
        .d_in  (d_in),
        .flush (flush),
        .r_out (r_out),
        .d_out (d_out),
        .d_cnt (d_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic r, input logic [15:0] d, input logic f);
        en = e; r_in = r; d_in = d; flush = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        #3;
        checks++;
        if (r_out !== 1'b0 || d_out !== 18'd0 || d_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: got r=%0b d=%0h c=%0d want 0/0/0", r_out, d_out, d_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'($urandom), 1'($urandom));
            tick();
            checks++;
            if (r_out !== 1'b0 || d_out !== 18'd0 || d_cnt !== 3'd0) begin
                errors++;
                $display("FAIL reset_held: got r=%0b d=%0h c=%0d want 0/0/0", r_out, d_out, d_cnt);
            end
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] samples [4];
        samples = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, samples[i], 1'b0);
            tick();
            checks++;
            if (r_out !== (i == 3)) begin
                errors++;
                $display("FAIL basic_rout[%0d]: got %0b want %0b", i, r_out, (i == 3));
            end
        end
        checks++;
        if (d_out !== 18'd10 || d_cnt !== 3'd4) begin
            errors++;
            $display("FAIL basic_sum: got d=%0d c=%0d want 10/4", d_out, d_cnt);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0);
        tick();
        checks++;
        if (r_out !== 1'b0 || d_out !== 18'd10 || d_cnt !== 3'd4) begin
            errors++;
            $display("FAIL basic_after: got r=%0b d=%0d c=%0d want 0/10/4", r_out, d_out, d_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'hFFFF, 1'b0);
            tick();
            checks++;
            if (r_out !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_rout[%0d]: got %0b want %0b", i, r_out, (i == 3 || i == 7));
            end
            if (r_out === 1'b1) begin
                pulses++;
                checks++;
                if (d_out !== 18'h3FFFC || d_cnt !== 3'd4) begin
                    errors++;
                    $display("FAIL b2b_sum[%0d]: got d=%0h c=%0d want 3fffc/4", i, d_out, d_cnt);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 16'd5, 1'b0); tick();
        drive(1'b1, 1'b1, 16'd7, 1'b0); tick();
        checks++;
        if (r_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: got r=%0b want 0", r_out);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b1); tick();
        checks++;
        if (r_out !== 1'b1 || d_out !== 18'd12 || d_cnt !== 3'd2) begin
            errors++;
            $display("FAIL flush_partial: got r=%0b d=%0d c=%0d want 1/12/2", r_out, d_out, d_cnt);
        end
        drive(1'b1, 1'b1, 16'd9, 1'b1); tick();
        checks++;
        if (r_out !== 1'b1 || d_out !== 18'd9 || d_cnt !== 3'd1) begin
            errors++;
            $display("FAIL flush_single: got r=%0b d=%0d c=%0d want 1/9/1", r_out, d_out, d_cnt);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b1); tick();
        checks++;
        if (r_out !== 1'b0 || d_out !== 18'd9 || d_cnt !== 3'd1) begin
            errors++;
            $display("FAIL flush_empty: got r=%0b d=%0d c=%0d want 0/9/1", r_out, d_out, d_cnt);
        end
        // A flush with three samples held, arriving with a fourth, closes a full window.
        drive(1'b1, 1'b1, 16'd1, 1'b0); tick();
        drive(1'b1, 1'b1, 16'd1, 1'b0); tick();
        drive(1'b1, 1'b1, 16'd1, 1'b0); tick();
        drive(1'b1, 1'b1, 16'd2, 1'b1); tick();
        checks++;
        if (r_out !== 1'b1 || d_out !== 18'd5 || d_cnt !== 3'd4) begin
            errors++;
            $display("FAIL flush_full: got r=%0b d=%0d c=%0d want 1/5/4", r_out, d_out, d_cnt);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0); tick();
    endtask

    task automatic test_enable();
        drive(1'b1, 1'b1, 16'd1, 1'b0); tick();
        drive(1'b1, 1'b1, 16'd2, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'd100, 1'(i == 1));
            tick();
            checks++;
            if (r_out !== 1'b0 || d_out !== 18'd5) begin
                errors++;
                $display("FAIL en_frozen[%0d]: got r=%0b d=%0d want 0/5", i, r_out, d_out);
            end
        end
        drive(1'b1, 1'b1, 16'd3, 1'b0); tick();
        drive(1'b1, 1'b1, 16'd4, 1'b0); tick();
        checks++;
        if (r_out !== 1'b1 || d_out !== 18'd10 || d_cnt !== 3'd4) begin
            errors++;
            $display("FAIL en_sum: got r=%0b d=%0d c=%0d want 1/10/4", r_out, d_out, d_cnt);
        end
        drive(1'b0, 1'b1, 16'd50, 1'b1); tick();
        checks++;
        if (r_out !== 1'b1 || d_out !== 18'd10 || d_cnt !== 3'd4) begin
            errors++;
            $display("FAIL en_hold_pulse: got r=%0b d=%0d c=%0d want 1/10/4", r_out, d_out, d_cnt);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0); tick();
        checks++;
        if (r_out !== 1'b0) begin
            errors++;
            $display("FAIL en_release: got r=%0b want 0", r_out);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'd7, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_out !== 1'b0 || d_out !== 18'd0 || d_cnt !== 3'd0) begin
            errors++;
            $display("FAIL midrst_async: got r=%0b d=%0d c=%0d want 0/0/0", r_out, d_out, d_cnt);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'd1, 1'b0);
            tick();
            checks++;
            if (r_out !== (i == 3)) begin
                errors++;
                $display("FAIL midrst_rout[%0d]: got %0b want %0b", i, r_out, (i == 3));
            end
        end
        checks++;
        if (d_out !== 18'd4 || d_cnt !== 3'd4) begin
            errors++;
            $display("FAIL midrst_sum: got d=%0d c=%0d want 4/4", d_out, d_cnt);
        end
        drive(1'b1, 1'b0, 16'd0, 1'b0); tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_enable();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
